// File: rtl/data_mem_pkg.sv
// Shared encodings, FSM states and the alignment-fault rule for the data memory.
package data_mem_pkg;

   localparam logic [1:0] SZ_BYTE = 2'd0;
   localparam logic [1:0] SZ_HALF = 2'd1;
   localparam logic [1:0] SZ_WORD = 2'd2;

   typedef enum logic [1:0] {
      ST_CLEAR,
      ST_IDLE,
      ST_RESP
   } state_e;

   // Illegal size, odd half, or word not on a word boundary.
   function automatic logic access_fault(input logic [1:0] size, input logic [1:0] offset);
      logic f;
      case (size)
         SZ_BYTE: f = 1'b0;
         SZ_HALF: f = offset[0];
         SZ_WORD: f = (offset != 2'b00);
         default: f = 1'b1;
      endcase
      return f;
   endfunction

endpackage

// File: rtl/data_mem_lane_align.sv
// Little-endian lane steering: store byte-enables/replicated data, load extraction and extension.
module mem_lane_align (
   input  logic [1:0]  size,
   input  logic [1:0]  offset,
   input  logic        is_signed,
   input  logic [31:0] wdata,
   input  logic [31:0] rword,
   output logic [3:0]  be_c,
   output logic [31:0] wdata_sh_c,
   output logic [31:0] rdata_ext_c
);
   import data_mem_pkg::*;

   logic [31:0] rword_sh;

   // Data is replicated across lanes so the byte-enable alone picks the target lane.
   always_comb begin
      be_c       = 4'b0000;
      wdata_sh_c = wdata;
      case (size)
         SZ_BYTE: begin
            be_c       = 4'b0001 << offset;
            wdata_sh_c = {4{wdata[7:0]}};
         end
         SZ_HALF: begin
            be_c       = offset[1] ? 4'b1100 : 4'b0011;
            wdata_sh_c = {2{wdata[15:0]}};
         end
         SZ_WORD: be_c = 4'b1111;
         default: be_c = 4'b0000;
      endcase
   end

   assign rword_sh = rword >> {offset, 3'b000};

   always_comb begin
      rdata_ext_c = rword;
      case (size)
         SZ_BYTE: rdata_ext_c = is_signed ? {{24{rword_sh[7]}}, rword_sh[7:0]}
                                          : {24'h000000, rword_sh[7:0]};
         SZ_HALF: rdata_ext_c = is_signed ? {{16{rword_sh[15]}}, rword_sh[15:0]}
                                          : {16'h0000, rword_sh[15:0]};
         default: rdata_ext_c = rword;
      endcase
   end

endmodule

// File: rtl/data_mem.sv
// MIPS load/store data memory: byte/half/word access, valid/ready handshake,
// alignment faults and a post-reset zeroing sweep.
module data_mem #(
   parameter int unsigned ADDR_W         = 10,
   parameter bit          CLEAR_ON_RESET = 1'b1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [1:0]        req_size,
   input  logic              req_signed,
   input  logic [ADDR_W+1:0] req_addr,
   input  logic [31:0]       req_wdata,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [31:0]       rsp_rdata,
   output logic              rsp_fault,
   output logic              busy
);
   import data_mem_pkg::*;

   localparam int unsigned DEPTH = 1 << ADDR_W;

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
   logic [31:0]       rsp_rdata_q, rsp_rdata_d;
   logic              rsp_fault_q, rsp_fault_d;
   logic [31:0]       mem_q [DEPTH];

   logic [ADDR_W-1:0] idx;
   logic [1:0]        off;
   logic [31:0]       rword;
   logic              fault_c, accept_c, st_we_c;
   logic [3:0]        be;
   logic [31:0]       wdata_sh, rdata_ext;

   assign idx   = req_addr[ADDR_W+1:2];
   assign off   = req_addr[1:0];
   assign rword = mem_q[idx];

   mem_lane_align u_align (
      .size        (req_size),
      .offset      (off),
      .is_signed   (req_signed),
      .wdata       (req_wdata),
      .rword       (rword),
      .be_c        (be),
      .wdata_sh_c  (wdata_sh),
      .rdata_ext_c (rdata_ext)
   );

   // In RESP a new request rides on the edge that consumes the current response.
   assign req_ready = rst_n && ((state_q == ST_IDLE) || ((state_q == ST_RESP) && rsp_ready));
   assign accept_c  = req_valid && req_ready;
   assign fault_c   = access_fault(req_size, off);
   assign st_we_c   = accept_c && req_we && !fault_c;

   always_comb begin
      state_d     = state_q;
      clr_cnt_d   = clr_cnt_q;
      rsp_rdata_d = rsp_rdata_q;
      rsp_fault_d = rsp_fault_q;
      case (state_q)
         ST_CLEAR: begin
            clr_cnt_d = clr_cnt_q + ADDR_W'(1);
            if (clr_cnt_q == '1) state_d = ST_IDLE;
         end
         ST_IDLE, ST_RESP: begin
            if (accept_c) begin
               state_d     = ST_RESP;
               rsp_rdata_d = (req_we || fault_c) ? 32'h0000_0000 : rdata_ext;
               rsp_fault_d = fault_c;
            end else if ((state_q == ST_RESP) && rsp_ready) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= CLEAR_ON_RESET ? ST_CLEAR : ST_IDLE;
         clr_cnt_q   <= '0;
         rsp_rdata_q <= 32'h0000_0000;
         rsp_fault_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         clr_cnt_q   <= clr_cnt_d;
         rsp_rdata_q <= rsp_rdata_d;
         rsp_fault_q <= rsp_fault_d;
      end
   end

   // Storage array: clear sweep has priority; stores commit on the accept edge.
   always_ff @(posedge clk) begin
      if (state_q == ST_CLEAR) begin
         mem_q[clr_cnt_q] <= 32'h0000_0000;
      end else if (st_we_c) begin
         for (int k = 0; k < 4; k++) begin
            if (be[k]) mem_q[idx][8*k +: 8] <= wdata_sh[8*k +: 8];
         end
      end
   end

   assign busy      = (state_q == ST_CLEAR);
   assign rsp_valid = (state_q == ST_RESP);
   assign rsp_rdata = rsp_rdata_q;
   assign rsp_fault = rsp_fault_q;

endmodule

// File: tb/tb_data_mem.sv
// Directed scoreboard bench for data_mem with ADDR_W=4 and clear-on-reset enabled.
module tb_data_mem;

   localparam int unsigned AW = 4;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          req_valid, req_ready, req_we, req_signed;
   logic [1:0]    req_size;
   logic [AW+1:0] req_addr;
   logic [31:0]   req_wdata;
   logic          rsp_valid, rsp_ready, rsp_fault, busy;
   logic [31:0]   rsp_rdata;

   typedef struct packed {
      logic [31:0] rdata;
      logic        fault;
   } exp_t;

   exp_t exp_q[$];
   int   tests = 0;
   int   fails = 0;

   always #5 clk = ~clk;

   data_mem #(.ADDR_W(AW), .CLEAR_ON_RESET(1'b1)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_we     (req_we),
      .req_size   (req_size),
      .req_signed (req_signed),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .rsp_valid  (rsp_valid),
      .rsp_ready  (rsp_ready),
      .rsp_rdata  (rsp_rdata),
      .rsp_fault  (rsp_fault),
      .busy       (busy)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic we, input logic [1:0] size, input logic sgn,
                        input logic [AW+1:0] addr, input logic [31:0] wd);
      req_valid  = 1'b1;
      req_we     = we;
      req_size   = size;
      req_signed = sgn;
      req_addr   = addr;
      req_wdata  = wd;
   endtask

   task automatic check_rsp(input string tag);
      int   n = 0;
      exp_t e;
      while (rsp_valid !== 1'b1 && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      chk({tag, "_valid"}, 32'(rsp_valid), 32'd1);
      chk({tag, "_sb_nonempty"}, 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         chk({tag, "_rdata"}, rsp_rdata, e.rdata);
         chk({tag, "_fault"}, 32'(rsp_fault), 32'(e.fault));
      end
   endtask

   // One complete transaction with rsp_ready held high.
   task automatic access(input string tag, input logic we, input logic [1:0] size, input logic sgn,
                         input logic [AW+1:0] addr, input logic [31:0] wd,
                         input logic [31:0] er, input logic ef);
      int n = 0;
      drive(we, size, sgn, addr, wd);
      rsp_ready = 1'b1;
      while (req_ready !== 1'b1 && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      chk({tag, "_req_ready"}, 32'(req_ready), 32'd1);
      exp_q.push_back('{rdata: er, fault: ef});
      @(posedge clk); #1;
      req_valid = 1'b0;
      check_rsp(tag);
      @(posedge clk); #1;
   endtask

   task automatic wait_clear(input string tag);
      int n = 0;
      while (busy === 1'b1 && n < 100) begin
         @(posedge clk); #1;
         n++;
      end
      chk({tag, "_cycles"}, 32'(n), 32'd16);
      chk({tag, "_ready_after"}, 32'(req_ready), 32'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, observed timeout expected $finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n      = 1'b0;
      req_valid  = 1'b0;
      req_we     = 1'b0;
      req_size   = 2'd0;
      req_signed = 1'b0;
      req_addr   = '0;
      req_wdata  = 32'h0;
      rsp_ready  = 1'b0;

      repeat (2) @(posedge clk);
      #1;
      chk("rst_req_ready", 32'(req_ready), 32'd0);
      chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("rst_rsp_rdata", rsp_rdata, 32'd0);
      chk("rst_rsp_fault", 32'(rsp_fault), 32'd0);
      chk("rst_busy", 32'(busy), 32'd1);
      rst_n = 1'b1;
      wait_clear("clear");

      access("lw_3c", 1'b0, 2'd2, 1'b0, 6'h3C, 32'h0, 32'h0000_0000, 1'b0);

      access("sw_08",  1'b1, 2'd2, 1'b0, 6'h08, 32'hDEAD_BEEF, 32'h0000_0000, 1'b0);
      access("lb_09",  1'b0, 2'd0, 1'b1, 6'h09, 32'h0, 32'hFFFF_FFBE, 1'b0);
      access("lbu_09", 1'b0, 2'd0, 1'b0, 6'h09, 32'h0, 32'h0000_00BE, 1'b0);
      access("lh_0a",  1'b0, 2'd1, 1'b1, 6'h0A, 32'h0, 32'hFFFF_DEAD, 1'b0);
      access("lhu_08", 1'b0, 2'd1, 1'b0, 6'h08, 32'h0, 32'h0000_BEEF, 1'b0);
      access("lw_signed_ignored", 1'b0, 2'd2, 1'b1, 6'h08, 32'h0, 32'hDEAD_BEEF, 1'b0);

      access("sb_0b",    1'b1, 2'd0, 1'b0, 6'h0B, 32'h0000_0011, 32'h0, 1'b0);
      access("lw_08_sb", 1'b0, 2'd2, 1'b0, 6'h08, 32'h0, 32'h11AD_BEEF, 1'b0);
      access("sh_08",    1'b1, 2'd1, 1'b0, 6'h08, 32'h0000_2233, 32'h0, 1'b0);
      access("lw_08_sh", 1'b0, 2'd2, 1'b0, 6'h08, 32'h0, 32'h11AD_2233, 1'b0);

      access("flt_lh_01",   1'b0, 2'd1, 1'b1, 6'h01, 32'h0, 32'h0, 1'b1);
      access("flt_lw_06",   1'b0, 2'd2, 1'b0, 6'h06, 32'h0, 32'h0, 1'b1);
      access("flt_size3",   1'b0, 2'd3, 1'b0, 6'h08, 32'h0, 32'h0, 1'b1);
      access("flt_sw_0a",   1'b1, 2'd2, 1'b0, 6'h0A, 32'hCAFE_F00D, 32'h0, 1'b1);
      access("flt_sh_09",   1'b1, 2'd1, 1'b0, 6'h09, 32'h0000_5555, 32'h0, 1'b1);
      access("lw_after_flt", 1'b0, 2'd2, 1'b0, 6'h08, 32'h0, 32'h11AD_2233, 1'b0);

      // Backpressure: response must hold while a competing request waits.
      drive(1'b0, 2'd1, 1'b0, 6'h08, 32'h0);
      rsp_ready = 1'b0;
      exp_q.push_back('{rdata: 32'h0000_2233, fault: 1'b0});
      @(posedge clk); #1;
      drive(1'b0, 2'd0, 1'b0, 6'h0B, 32'h0);
      for (int i = 0; i < 3; i++) begin
         chk("bp_valid", 32'(rsp_valid), 32'd1);
         chk("bp_rdata", rsp_rdata, 32'h0000_2233);
         chk("bp_fault", 32'(rsp_fault), 32'd0);
         chk("bp_req_ready", 32'(req_ready), 32'd0);
         @(posedge clk); #1;
      end
      check_rsp("bp_held");
      rsp_ready = 1'b1;
      #1;
      chk("bp_same_edge_ready", 32'(req_ready), 32'd1);
      exp_q.push_back('{rdata: 32'h0000_0011, fault: 1'b0});
      @(posedge clk); #1;
      req_valid = 1'b0;
      chk("bp_next_valid_1cyc", 32'(rsp_valid), 32'd1);
      check_rsp("bp_next");
      @(posedge clk); #1;
      chk("bp_idle_after", 32'(rsp_valid), 32'd0);

      // Reset while a response is pending.
      drive(1'b0, 2'd2, 1'b0, 6'h08, 32'h0);
      rsp_ready = 1'b0;
      @(posedge clk); #1;
      req_valid = 1'b0;
      chk("mid_in_resp", 32'(rsp_valid), 32'd1);
      rst_n = 1'b0;
      @(posedge clk); #1;
      exp_q.delete();
      chk("mid_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("mid_rsp_rdata", rsp_rdata, 32'd0);
      chk("mid_busy", 32'(busy), 32'd1);
      chk("mid_req_ready", 32'(req_ready), 32'd0);
      rst_n = 1'b1;
      wait_clear("reclear");
      access("lw_08_cleared", 1'b0, 2'd2, 1'b0, 6'h08, 32'h0, 32'h0000_0000, 1'b0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/data_mem.md
# data_mem

Parametrised data memory for the MIPS CPU load/store path, replacing the flat word RAM. It supports byte/half/word accesses with MIPS sign/zero extension, a valid/ready request and response handshake, alignment-fault reporting, and a hardware clear sequence after reset. It sits between the pipeline MEM stage and the word-addressed storage array.

## Interface
- ADDR_W, 10, word-address bits; depth = 2**ADDR_W words of 32 bits
- CLEAR_ON_RESET, 1, if 1 every word is zeroed after reset before the first request is accepted
- clk  in  1  single clock, all state updates on rising edge
- rst_n  in  1  synchronous active-low reset, sampled on rising edge of clk
- req_valid  in  1  request present
- req_ready  out  1  request accepted on an edge where req_valid && req_ready
- req_we  in  1  1 = store, 0 = load
- req_size  in  2  0 = byte, 1 = half, 2 = word, 3 = illegal
- req_signed  in  1  loads only: 1 = sign-extend (lb/lh), 0 = zero-extend (lbu/lhu)
- req_addr  in  ADDR_W+2  byte address; [ADDR_W+1:2] = word index, [1:0] = lane offset
- req_wdata  in  32  store data, right-justified (byte in [7:0], half in [15:0])
- rsp_valid  out  1  response present
- rsp_ready  in  1  response consumed on an edge where rsp_valid && rsp_ready
- rsp_rdata  out  32  extended load data; 0 for stores and faults
- rsp_fault  out  1  misaligned or illegal-size request
- busy  out  1  clear sequence in progress

## Operation
- States: CLEAR, IDLE, RESP. A reset edge enters CLEAR if CLEAR_ON_RESET=1, otherwise IDLE.
- CLEAR: a counter starts at 0 and writes zero to one word per cycle. After word 2**ADDR_W-1 is written, the state moves to IDLE. busy=1 and req_ready=0 throughout.
- IDLE: req_ready=1. On accept, the state moves to RESP and the response registers load.
- RESP: rsp_valid=1, and outputs hold stable until rsp_ready. req_ready = rsp_ready, so a new request can be accepted on the same edge that the response is consumed; RESP is then re-entered with the new response. If the response is consumed with no new request, the state moves to IDLE.
- Byte lanes are little-endian: lane k = bits [8k+7:8k], selected by req_addr[1:0]. A half uses lane offset 0 or 2.
- Store: only the addressed lanes are written, on the accept edge. The other lanes are unchanged. Response: rdata=0, fault=0.
- Load: the word is read at the accept edge. The addressed lane(s) are extracted to bit 0 and extended per req_signed; req_signed is ignored for word loads.
- Fault conditions: size=3, half with addr[0]=1, or word with addr[1:0]≠0. On a fault there is no memory write, rdata=0 and fault=1; the response is otherwise normal.

## Timing
- Reset values while rst_n=0 and on the edge after: req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_fault=0. busy=CLEAR_ON_RESET.
- Clear duration is exactly 2**ADDR_W cycles after the reset edge, so the first req_ready=1 is in cycle 2**ADDR_W+1.
- Load latency is 1: a request accepted at edge N gives rsp_valid high from cycle N+1.
- Peak throughput is one access per cycle when rsp_ready is held at 1.
- Store-then-load to the same word on consecutive accepts returns the new data; no forwarding is needed because the write commits at the accept edge.
- Reset mid-operation (in CLEAR or RESP) discards the pending response and restarts the clear from word 0. Memory contents are undefined only when CLEAR_ON_RESET=0.
- req_* inputs are sampled only on the accept edge and may change freely otherwise.

## Structure
- Package data_mem_pkg holds:
  - size encodings SZ_BYTE=2'd0, SZ_HALF=2'd1, SZ_WORD=2'd2;
  - state enum {ST_CLEAR, ST_IDLE, ST_RESP};
  - the fault-check function.
- Sub-module mem_lane_align (combinational) provides:
  - store path: byte-enable mask and lane-shifted write data from size/offset/wdata;
  - load path: lane extraction and sign/zero extension.
- The top level holds the FSM, the clear counter, the storage array and the response registers.

## Test plan
- Reset with ADDR_W=4, CLEAR_ON_RESET=1: busy for 16 cycles, then req_ready=1; a load of word addr 0x3C returns 0x00000000.
- Word store 0xDEADBEEF @0x08, then lb @0x09 gives 0xFFFFFFBE, lbu @0x09 gives 0x000000BE, lh @0x0A gives 0xFFFFDEAD, lhu @0x08 gives 0x0000BEEF.
- sb 0x11 @0x0B over 0xDEADBEEF, then lw @0x08 gives 0x11ADBEEF; sh 0x2233 @0x08 then gives 0x11AD2233.
- Faults: lh @0x01, lw @0x06, size=3 all give rsp_fault=1, rdata=0; a prior lw of that word shows it unchanged after a faulting store.
- Backpressure: hold rsp_ready=0 for 3 cycles, and rsp_rdata/rsp_fault stay stable with req_ready=0. Then rsp_ready=1 with a new req_valid: the request is accepted on the same edge and the next response follows in 1 cycle.
- Assert rst_n=0 while in RESP: rsp_valid drops on the next edge and the clear restarts at word 0, taking 16 full cycles.
